prover_compute_v_early_seq: RTL and testbench



---
 rtl/prover_seq_pkg.sv | 29 ++
 rtl/prover_seq_counter.sv | 39 +++
 rtl/prover_compute_v_early_seq.sv | 195 +++++++++++++++++++
 tb/tb_prover_compute_v_early_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prover_seq_pkg.sv
// Shared types and derived constants for the prover compute-V early sequencer.
`ifndef F_NBITS
`define F_NBITS 61
`endif

package prover_seq_pkg;

  localparam int F_NBITS = `F_NBITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FEED,
    ST_DRAIN,
    ST_INTERP,
    ST_CAPT
  } seq_state_e;

  // Number of beta batches fed to the gates bank per round.
  function automatic int beta_per(input int n_copy_bits, input int n_par_bits);
    return 1 << (n_copy_bits - n_par_bits - 1);
  endfunction

  // Batch counter width; never narrower than one bit.
  function automatic int batch_width(input int n_copy_bits, input int n_par_bits);
    return (n_copy_bits - n_par_bits - 1 > 1) ? (n_copy_bits - n_par_bits - 1) : 1;
  endfunction

endpackage

// File: rtl/prover_seq_counter.sv
// Up-counter with synchronous clear, increment and terminal-count flag.
module prover_seq_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             incr,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             at_last
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear wins over increment so a new run always starts from zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (incr) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign at_last = (count_q == last);

endmodule

// File: rtl/prover_compute_v_early_seq.sv
// Sequencer for the early compute-V phase: loads betas, feeds the gates bank,
// drains, interpolates and captures one set of cubic coefficients per round.
module prover_compute_v_early_seq
  import prover_seq_pkg::*;
#(
  parameter int nCopyBits  = 3,
  parameter int nParBits   = 1,
  parameter int nRoundBits = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [nRoundBits-1:0]          n_rounds,
  input  logic                           src_valid,
  output logic                           src_req,
  input  logic [(1<<nParBits)-1:0]       bank_in_ready,
  input  logic                           bank_out_ready,
  input  logic [3:0][F_NBITS-1:0]        bank_c,
  output logic [3:0]                     beta_en,
  output logic [(1<<nParBits)-1:0]       en,
  output logic                           interp_en,
  output logic [nRoundBits-1:0]          round_idx,
  output logic [3:0][F_NBITS-1:0]        c_out,
  output logic                           round_done,
  output logic                           busy,
  output logic                           done
);

  localparam int nParallel = 1 << nParBits;
  localparam int nBetaPer  = beta_per(nCopyBits, nParBits);
  localparam int BATCH_W   = batch_width(nCopyBits, nParBits);

  if (nCopyBits - nParBits < 1) begin : g_bad_params
    $error("prover_compute_v_early_seq: nCopyBits-nParBits must be >= 1");
  end

  seq_state_e                state_q, state_d;
  logic [nRoundBits-1:0]     n_rounds_q, n_rounds_d;
  logic                      first_q, first_d;
  logic [3:0]                beta_en_q, beta_en_d;
  logic [nParallel-1:0]      en_q, en_d;
  logic                      interp_en_q, interp_en_d;
  logic                      src_req_q, src_req_d;
  logic                      round_done_q, round_done_d;
  logic                      done_q, done_d;
  logic [3:0][F_NBITS-1:0]   c_out_q, c_out_d;

  logic                      batch_clear, batch_incr, batch_last;
  logic [BATCH_W-1:0]        batch_count;
  logic                      round_clear, round_incr, round_last;
  logic [nRoundBits-1:0]     round_count;

  prover_seq_counter #(.WIDTH(BATCH_W)) u_batch_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (batch_clear),
    .incr    (batch_incr),
    .last    (BATCH_W'(nBetaPer - 1)),
    .count   (batch_count),
    .at_last (batch_last)
  );

  prover_seq_counter #(.WIDTH(nRoundBits)) u_round_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (round_clear),
    .incr    (round_incr),
    .last    (n_rounds_q - nRoundBits'(1)),
    .count   (round_count),
    .at_last (round_last)
  );

  // Next-state and registered-pulse logic. The round index advances on the
  // first ST_LOAD cycle after a capture, so round_idx still names the round
  // whose coefficients appear on c_out while round_done is high.
  always_comb begin
    state_d      = state_q;
    n_rounds_d   = n_rounds_q;
    first_d      = first_q;
    beta_en_d    = '0;
    en_d         = '0;
    interp_en_d  = 1'b0;
    src_req_d    = 1'b0;
    round_done_d = 1'b0;
    done_d       = 1'b0;
    c_out_d      = c_out_q;
    batch_clear  = 1'b0;
    batch_incr   = 1'b0;
    round_clear  = 1'b0;
    round_incr   = (state_q == ST_LOAD) && round_done_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (n_rounds != '0) begin
            n_rounds_d  = n_rounds;
            batch_clear = 1'b1;
            round_clear = 1'b1;
            src_req_d   = 1'b1;
            state_d     = ST_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (src_valid) begin
          beta_en_d = 4'b1111;
          state_d   = ST_FEED;
        end
      end
      ST_FEED: begin
        if ((&bank_in_ready) && src_valid) begin
          en_d = '1;
          if (!batch_last) begin
            batch_incr = 1'b1;
            src_req_d  = 1'b1;
          end else begin
            first_d = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (first_q) begin
          first_d = 1'b0;
        end else if (bank_out_ready) begin
          interp_en_d = 1'b1;
          first_d     = 1'b1;
          state_d     = ST_INTERP;
        end
      end
      ST_INTERP: begin
        if (first_q) begin
          first_d = 1'b0;
        end else if (bank_out_ready) begin
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        c_out_d      = bank_c;
        round_done_d = 1'b1;
        if (round_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          batch_clear = 1'b1;
          src_req_d   = 1'b1;
          state_d     = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched round count, coefficient and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      n_rounds_q   <= '0;
      first_q      <= 1'b0;
      beta_en_q    <= '0;
      en_q         <= '0;
      interp_en_q  <= 1'b0;
      src_req_q    <= 1'b0;
      round_done_q <= 1'b0;
      done_q       <= 1'b0;
      c_out_q      <= '0;
    end else begin
      state_q      <= state_d;
      n_rounds_q   <= n_rounds_d;
      first_q      <= first_d;
      beta_en_q    <= beta_en_d;
      en_q         <= en_d;
      interp_en_q  <= interp_en_d;
      src_req_q    <= src_req_d;
      round_done_q <= round_done_d;
      done_q       <= done_d;
      c_out_q      <= c_out_d;
    end
  end

  assign src_req    = src_req_q;
  assign beta_en    = beta_en_q;
  assign en         = en_q;
  assign interp_en  = interp_en_q;
  assign round_idx  = round_count;
  assign c_out      = c_out_q;
  assign round_done = round_done_q;
  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_prover_compute_v_early_seq.sv
// Self-checking bench for prover_compute_v_early_seq with a small gates-bank model.
module tb_prover_compute_v_early_seq;
  import prover_seq_pkg::*;

  localparam int NROUND = 6;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [NROUND-1:0]        n_rounds;
  logic                     src_valid;
  logic                     src_req;
  logic [1:0]               bank_in_ready;
  logic                     bank_out_ready;
  logic [3:0][F_NBITS-1:0]  bank_c;
  logic [3:0]               beta_en;
  logic [1:0]               en;
  logic                     interp_en;
  logic [NROUND-1:0]        round_idx;
  logic [3:0][F_NBITS-1:0]  c_out;
  logic                     round_done;
  logic                     busy;
  logic                     done;

  always #5 clk = ~clk;

  prover_compute_v_early_seq #(
    .nCopyBits  (3),
    .nParBits   (1),
    .nRoundBits (NROUND)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .n_rounds       (n_rounds),
    .src_valid      (src_valid),
    .src_req        (src_req),
    .bank_in_ready  (bank_in_ready),
    .bank_out_ready (bank_out_ready),
    .bank_c         (bank_c),
    .beta_en        (beta_en),
    .en             (en),
    .interp_en      (interp_en),
    .round_idx      (round_idx),
    .c_out          (c_out),
    .round_done     (round_done),
    .busy           (busy),
    .done           (done)
  );

  // Gates-bank model: busy for 3 cycles after en or interp_en; each interpolation
  // publishes coefficients {16v+1, 16v+2, 16v+3, 16v+4} where v counts interpolations.
  int bank_busy    = 0;
  int interp_busy  = 0;
  int interp_total = 0;

  always @(posedge clk) begin
    if (|en) bank_busy <= 3;
    else if (bank_busy != 0) bank_busy <= bank_busy - 1;
    if (interp_en) begin
      interp_busy <= 3;
      for (int i = 0; i < 4; i++) bank_c[i] <= F_NBITS'(interp_total * 16 + i + 1);
      interp_total <= interp_total + 1;
    end else if (interp_busy != 0) begin
      interp_busy <= interp_busy - 1;
    end
  end

  assign bank_in_ready  = (bank_busy == 0 && !(|en)) ? 2'b11 : 2'b00;
  assign bank_out_ready = (bank_busy == 0) && !(|en) && (interp_busy == 0) && !interp_en;

  typedef struct {
    int idx;
    int val;
    bit last;
  } exp_t;

  exp_t sb[$];

  int total_checks = 0;
  int bad_checks   = 0;
  int cyc = 0;
  int n_beta = 0, n_en = 0, n_interp = 0, n_src = 0, n_done = 0, n_rd = 0, n_overlap = 0;
  int t_beta = 0, t_en = 0, t_interp = 0, t_done = 0, t_rd = 0;
  int b_beta, b_en, b_interp, b_src, b_done, b_rd;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge, log pulses and score any round_done.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (|beta_en) begin
      n_beta++; t_beta = cyc;
      checkOutput("beta_en_value", beta_en, 4'hF);
    end
    if (|en) begin
      n_en++; t_en = cyc;
      checkOutput("en_value", en, 2'b11);
      if (|beta_en) n_overlap++;
    end
    if (interp_en) begin n_interp++; t_interp = cyc; end
    if (src_req) n_src++;
    if (done) begin n_done++; t_done = cyc; end
    if (round_done) begin
      n_rd++; t_rd = cyc;
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", round_done, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("round_idx", round_idx, e.idx);
        for (int i = 0; i < 4; i++) checkOutput("c_out", c_out[i], e.val * 16 + i + 1);
        checkOutput("done_with_last", done, e.last);
      end
    end
  endtask

  task automatic snap();
    b_beta = n_beta; b_en = n_en; b_interp = n_interp;
    b_src = n_src; b_done = n_done; b_rd = n_rd;
  endtask

  task automatic applyStimulus(input int n);
    exp_t e;
    start    = 1'b1;
    n_rounds = NROUND'(n);
    for (int k = 0; k < n; k++) begin
      e.idx = k; e.val = interp_total + k; e.last = (k == n - 1);
      sb.push_back(e);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done) seen = 1;
    end
    checkOutput("done_seen", seen, 1);
  endtask

  task automatic checkIdleClean(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_c_out"}, (c_out != '0), 0);
    checkOutput({tag, "_pulses"}, {src_req, beta_en, en, interp_en, round_done, done}, 0);
    checkOutput({tag, "_round_idx"}, round_idx, 0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; n_rounds = '0; src_valid = 1'b1;
    repeat (3) tick();
    checkIdleClean("reset");
    rst = 1'b0;

    // Single round: ordering and pulse counts.
    snap();
    applyStimulus(1);
    waitDone(500);
    checkOutput("a_c0", c_out[0], 1);
    checkOutput("a_c3", c_out[3], 4);
    checkOutput("a_done_eq_rd", t_done, t_rd);
    tick();
    checkOutput("a_done_one_cycle", done, 0);
    checkOutput("a_busy_after", busy, 0);
    checkOutput("a_n_beta", n_beta - b_beta, 1);
    checkOutput("a_n_en", n_en - b_en, 2);
    checkOutput("a_n_interp", n_interp - b_interp, 1);
    checkOutput("a_n_src", n_src - b_src, 2);
    checkOutput("a_n_rd", n_rd - b_rd, 1);
    checkOutput("a_beta_before_en", (t_beta < t_en), 1);
    checkOutput("a_en_before_interp", (t_en < t_interp), 1);
    checkOutput("a_interp_before_rd", (t_interp < t_rd), 1);

    // Three rounds.
    snap();
    applyStimulus(3);
    waitDone(1500);
    tick();
    checkOutput("b_n_rd", n_rd - b_rd, 3);
    checkOutput("b_n_done", n_done - b_done, 1);
    checkOutput("b_n_beta", n_beta - b_beta, 3);
    checkOutput("b_n_en", n_en - b_en, 6);
    checkOutput("b_sb_empty", sb.size(), 0);

    // Zero rounds: done next cycle only, nothing else.
    snap();
    applyStimulus(0);
    checkOutput("c_done", done, 1);
    checkOutput("c_busy", busy, 0);
    tick();
    checkOutput("c_done_drop", done, 0);
    repeat (3) tick();
    checkOutput("c_n_done", n_done - b_done, 1);
    checkOutput("c_no_bank", (n_beta - b_beta) + (n_en - b_en) + (n_interp - b_interp), 0);

    // Stall in ST_FEED with src_valid low.
    snap();
    applyStimulus(1);
    cnt = 0;
    for (int i = 0; i < 20 && !(|beta_en); i++) tick();
    checkOutput("d_beta_seen", beta_en, 4'hF);
    src_valid = 1'b0;
    snap();
    repeat (10) tick();
    checkOutput("d_stall_no_en", n_en - b_en, 0);
    checkOutput("d_stall_no_src", n_src - b_src, 0);
    checkOutput("d_stall_busy", busy, 1);
    src_valid = 1'b1;
    tick();
    checkOutput("d_en_on_valid", en, 2'b11);
    waitDone(500);
    tick();

    // Start while busy is ignored.
    snap();
    applyStimulus(2);
    repeat (3) tick();
    start = 1'b1; n_rounds = NROUND'(5);
    tick();
    start = 1'b0;
    waitDone(1500);
    tick();
    checkOutput("e_n_rd", n_rd - b_rd, 2);
    checkOutput("e_n_done", n_done - b_done, 1);
    checkOutput("e_busy_after", busy, 0);

    // Reset in ST_DRAIN, then a fresh run.
    applyStimulus(1);
    for (int i = 0; i < 200 && cnt < 2; i++) begin
      tick();
      if (|en) cnt++;
    end
    checkOutput("f_reached_drain", cnt, 2);
    rst = 1'b1;
    tick();
    checkIdleClean("f_reset");
    rst = 1'b0;
    sb.delete();
    snap();
    applyStimulus(1);
    waitDone(500);
    tick();
    checkOutput("f_n_rd", n_rd - b_rd, 1);
    checkOutput("f_busy_after", busy, 0);
    checkOutput("f_sb_empty", sb.size(), 0);

    checkOutput("no_en_beta_overlap", n_overlap, 0);
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
